sparc_data_ram: RTL and testbench
=================================

// Module: sparc_data_ram
// PURPOSE
//  Byte-addressable data memory for the SPARC datapath, downstream of the data-type decoder.
//  Consumes that decoder's size/sign pair plus the control unit's MOV/RW.
//  Performs big-endian byte/halfword/word loads and stores with a fixed, parameterised latency.
//  Loads are sign- or zero-extended to 32 bits. Completion is signalled to the control-unit FSM with MFC.
// PARAMETERS
//  ADDR_W   9  byte-address width; memory depth = 2**ADDR_W bytes
//  LATENCY  2  edges from MOV sampling to MFC rise (legal range 1..15)
// PORTS
//  clk        in   1       system clock, rising-edge
//  reset      in   1       synchronous, active-high reset
//  mov        in   1       memory operation valid (request)
//  rw         in   1       1 = load (read), 0 = store (write)
//  size       in   2       00 byte, 01 halfword, 10 word, 11 treated as word
//  sign       in   1       1 = sign-extend load, 0 = zero-extend; ignored on stores
//  addr       in   ADDR_W  byte address
//  data_in    in   32      store data, right-justified
//  data_out   out  32      load result, registered
//  mfc        out  1       memory function complete
//  align_err  out  1       misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset is synchronous and active-high.
//  - Reset values: data_out=0, mfc=0, align_err=0, FSM=IDLE, latency counter=0.
//    RAM contents are not cleared.
//  - FSM IDLE->BUSY: in IDLE, mov=1 at edge E0 latches rw/size/sign/addr/data_in and enters BUSY.
//    Input changes after E0 are ignored until IDLE is re-entered.
//  - BUSY->DONE: counter runs; at edge E0+LATENCY the op commits, mfc goes 1, FSM enters DONE.
//    Load: data_out updates on the same edge. Store: RAM bytes written on the same edge.
//  - DONE: mfc held 1 while mov=1. The first edge seeing mov=0 clears mfc and enters IDLE.
//    A new request is accepted no earlier than the edge after that.
//  - mov dropped during BUSY: the op still completes, mfc is high for exactly one cycle, then IDLE.
//  - Byte order is big-endian: the byte at addr is the MSB. hw = {m[a],m[a+1]}; word = {m[a]..m[a+3]}.
//  - Loads: byte puts m[a] into [7:0]; hw into [15:0]. Upper bits = sign ? replicate MSB : 0.
//  - Stores: byte writes data_in[7:0]; hw data_in[15:0]; word data_in[31:0]. Other bytes untouched.
//  - data_out holds its last load value across stores and idle cycles.
//  - Address arithmetic is modulo 2**ADDR_W.
//  - Reset on any edge up to and including the commit edge aborts: no RAM write, mfc stays 0.
// CONFIGURATION
//  Macro DATA_RAM_ALIGN_CHECK_EN:
//  - defined: hw with addr[0]!=0, or word with addr[1:0]!=0, is rejected.
//    align_err=1 together with mfc (same edge, same duration); no RAM write; data_out unchanged.
//    align_err clears with mfc.
//  - undefined: align_err tied 0. Address is force-aligned (hw clears addr[0], word clears
//    addr[1:0]) and the access proceeds normally; no access ever straddles the top of memory.
// TESTING (LATENCY=2, ADDR_W=9)
//  1. Reset held 2 cycles, mov=1 during reset -> data_out=0, mfc=0, align_err=0, no op started.
//  2. Store word 0x8A3BC4D5 @0x010, then load @0x010:
//     LB unsigned -> 0x0000008A; LB signed -> 0xFFFFFF8A; LH signed @0x012 -> 0xFFFFC4D5;
//     LW -> 0x8A3BC4D5; mfc rises exactly 2 edges after mov is sampled.
//  3. Store byte 0x7F @0x011, then LW @0x010 -> 0x8A7FC4D5; LH unsigned @0x010 -> 0x00008A7F.
//  4. LW @0x013: with macro -> align_err=1, mfc=1, data_out unchanged; store word @0x013
//     leaves RAM unchanged. Without macro -> LW returns the word @0x010.
//  5. Store word 0xDEADBEEF @0x1FC with reset asserted on edge E0+1 -> mfc never rises;
//     LW @0x1FC returns the prior contents.
//  6. mov held 5 cycles after mfc -> mfc stays 1, no second op. mov=0 -> mfc=0 next edge.
//     mov dropped one cycle after E0 -> mfc pulses exactly one cycle, store still committed.

Source files
------------

// File: rtl/sparc_data_ram_if.sv
// sparc_data_ram_if: request/response bus between the control unit (master) and the data RAM (slave)
interface sparc_data_ram_if #(parameter int ADDR_W = 9);
  logic              mov;
  logic              rw;
  logic [1:0]        size;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              align_err;
  modport master (output mov, rw, size, sign, addr, data_in, input data_out, mfc, align_err);
  modport slave (input mov, rw, size, sign, addr, data_in, output data_out, mfc, align_err);
endinterface

// File: rtl/sparc_data_ram.sv
// sparc_data_ram: big-endian byte/half/word data RAM with fixed latency and MFC handshake.
// Define DATA_RAM_ALIGN_CHECK_EN to reject misaligned accesses instead of force-aligning them.
module sparc_data_ram #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             reset,
  sparc_data_ram_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              rw_q, sign_q, drop_q, mfc_q, align_err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, data_out_q, data_out_d;
  logic [7:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              commit, misalign, we;
  always_comb begin
    a0 = size_q[1] ? {addr_q[ADDR_W-1:2], 2'b00} : size_q[0] ? {addr_q[ADDR_W-1:1], 1'b0} : addr_q;
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
`ifdef DATA_RAM_ALIGN_CHECK_EN
    misalign = size_q[1] ? |addr_q[1:0] : size_q[0] & addr_q[0];
`else
    misalign = 1'b0;
`endif
    commit = state_q == BUSY && cnt_q == 4'(LATENCY);
    we = commit & ~rw_q & ~misalign & ~reset;
    data_out_d = size_q[1] ? {b0, b1, b2, b3} :
                 size_q[0] ? {{16{sign_q & b0[7]}}, b0, b1} : {{24{sign_q & b0[7]}}, b0};
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      mfc_q       <= 1'b0;
      align_err_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.mov) begin
          rw_q    <= bus.rw;
          size_q  <= bus.size;
          sign_q  <= bus.sign;
          addr_q  <= bus.addr;
          wdata_q <= bus.data_in;
          cnt_q   <= 4'd1;
          drop_q  <= 1'b0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q  <= cnt_q + 4'd1;
          drop_q <= drop_q | ~bus.mov;
          if (commit) begin
            state_q     <= DONE;
            cnt_q       <= '0;
            mfc_q       <= 1'b1;
            align_err_q <= misalign;
            if (rw_q && !misalign) data_out_q <= data_out_d;
          end
        end
        DONE: if (!bus.mov || drop_q) begin
          state_q     <= IDLE;
          mfc_q       <= 1'b0;
          align_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  // RAM is never reset; reset on the commit edge suppresses the write through we
  always_ff @(posedge clk)
    if (we) begin
      mem[a0] <= size_q[1] ? wdata_q[31:24] : size_q[0] ? wdata_q[15:8] : wdata_q[7:0];
      if (size_q != 2'b00) mem[a1] <= size_q[1] ? wdata_q[23:16] : wdata_q[7:0];
      if (size_q[1]) begin
        mem[a2] <= wdata_q[15:8];
        mem[a3] <= wdata_q[7:0];
      end
    end
  assign bus.data_out  = data_out_q;
  assign bus.mfc       = mfc_q;
  assign bus.align_err = align_err_q;
endmodule

// File: tb/tb_sparc_data_ram.sv
// tb_sparc_data_ram: directed + randomized checks of sparc_data_ram against a byte-array reference model
module tb_sparc_data_ram;
  localparam int ADDR_W = 9;
  localparam int LAT    = 2;
  localparam int DEPTH  = 512;
`ifdef DATA_RAM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_dout = '0;

  sparc_data_ram_if #(.ADDR_W(ADDR_W)) bus ();
  sparc_data_ram #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int width(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [8:0] a);
    return ALIGN_CHK && (int'(a) % width(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [8:0] a);
    int w = width(sz);
    int ea = (int'(a) / w) * w;
    logic [31:0] v = '0;
    for (int k = 0; k < w; k++) v = (v << 8) | 32'(ref_mem[(ea + k) % DEPTH]);
    if (sg && w < 4 && v[8*w-1]) v = v | (32'hFFFF_FFFF << (8 * w));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
    int w = width(sz);
    int ea = (int'(a) / w) * w;
    for (int k = 0; k < w; k++) ref_mem[(ea + k) % DEPTH] = 8'(d >> (8 * (w - 1 - k)));
  endtask

  task automatic op(input string tag, input logic r, input logic [1:0] sz, input logic sg,
                    input logic [8:0] a, input logic [31:0] d, input int hold);
    int n = 0;
    bit mis = misaligned(sz, a);
    @(negedge clk);
    bus.mov = 1'b1; bus.rw = r; bus.size = sz; bus.sign = sg; bus.addr = a; bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.addr = 9'($urandom); bus.data_in = $urandom; bus.rw = ~r;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.mfc && n < 20);
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_aerr"}, 32'(bus.align_err), 32'(mis));
    if (!mis) begin
      if (r) ref_dout = ref_load(sz, sg, a);
      else ref_store(sz, a, d);
    end
    chk({tag, "_dout"}, bus.data_out, ref_dout);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_mfc"}, 32'(bus.mfc), 1);
      chk({tag, "_hold_dout"}, bus.data_out, ref_dout);
    end
    @(negedge clk);
    bus.mov = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_mfc_clr"}, 32'(bus.mfc), 0);
    chk({tag, "_aerr_clr"}, 32'(bus.align_err), 0);
  endtask

  task automatic abort_store(input string tag, input logic [8:0] a, input logic [31:0] d, input int k);
    @(negedge clk);
    bus.mov = 1'b1; bus.rw = 1'b0; bus.size = 2'd2; bus.sign = 1'b0; bus.addr = a; bus.data_in = d;
    @(posedge clk);
    repeat (k - 1) begin
      @(posedge clk); #1;
      chk({tag, "_pre_mfc"}, 32'(bus.mfc), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rst_mfc"}, 32'(bus.mfc), 0);
    ref_dout = '0;
    @(negedge clk);
    reset = 1'b0; bus.mov = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_post_mfc"}, 32'(bus.mfc), 0);
    chk({tag, "_post_dout"}, bus.data_out, 32'h0);
  endtask

  initial begin
    int n;
    bus.mov = 1'b1; bus.rw = 1'b0; bus.size = 2'd2; bus.sign = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", bus.data_out, 32'h0);
    chk("rst_mfc", 32'(bus.mfc), 0);
    chk("rst_aerr", 32'(bus.align_err), 0);
    @(negedge clk);
    reset = 1'b0; bus.mov = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_op", 32'(bus.mfc), 0);

    for (int i = 0; i < DEPTH / 4; i++) op("init", 1'b0, 2'd2, 1'b0, 9'(4 * i), $urandom, 0);

    op("sw10", 1'b0, 2'd2, 1'b0, 9'h010, 32'h8A3BC4D5, 0);
    op("lbu10", 1'b1, 2'd0, 1'b0, 9'h010, 0, 0);
    chk("lbu10_val", bus.data_out, 32'h0000008A);
    op("lbs10", 1'b1, 2'd0, 1'b1, 9'h010, 0, 0);
    chk("lbs10_val", bus.data_out, 32'hFFFFFF8A);
    op("lhs12", 1'b1, 2'd1, 1'b1, 9'h012, 0, 0);
    chk("lhs12_val", bus.data_out, 32'hFFFFC4D5);
    op("lw10", 1'b1, 2'd2, 1'b0, 9'h010, 0, 0);
    chk("lw10_val", bus.data_out, 32'h8A3BC4D5);

    op("sb11", 1'b0, 2'd0, 1'b0, 9'h011, 32'h0000007F, 0);
    op("lw10b", 1'b1, 2'd2, 1'b0, 9'h010, 0, 0);
    chk("lw10b_val", bus.data_out, 32'h8A7FC4D5);
    op("lhu10", 1'b1, 2'd1, 1'b0, 9'h010, 0, 0);
    chk("lhu10_val", bus.data_out, 32'h00008A7F);

    op("lw13", 1'b1, 2'd2, 1'b0, 9'h013, 0, 0);
    chk("lw13_val", bus.data_out, ALIGN_CHK ? 32'h00008A7F : 32'h8A7FC4D5);
    op("sw13", 1'b0, 2'd2, 1'b0, 9'h013, 32'h11223344, 0);
    op("lw10c", 1'b1, 2'd3, 1'b0, 9'h010, 0, 0);
    chk("lw10c_val", bus.data_out, ALIGN_CHK ? 32'h8A7FC4D5 : 32'h11223344);

    abort_store("abort1", 9'h1FC, 32'hDEADBEEF, 1);
    op("lw1fc", 1'b1, 2'd2, 1'b0, 9'h1FC, 0, 0);
    abort_store("abort2", 9'h1FC, 32'hDEADBEEF, 2);
    op("lw1fcb", 1'b1, 2'd2, 1'b0, 9'h1FC, 0, 0);

    op("hold", 1'b1, 2'd2, 1'b0, 9'h010, 0, 5);

    @(negedge clk);
    bus.mov = 1'b1; bus.rw = 1'b0; bus.size = 2'd2; bus.addr = 9'h020; bus.data_in = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus.mov = 1'b0;
    @(posedge clk); #1;
    chk("drop_e1_mfc", 32'(bus.mfc), 0);
    @(posedge clk); #1;
    chk("drop_e2_mfc", 32'(bus.mfc), 1);
    ref_store(2'd2, 9'h020, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("drop_e3_mfc", 32'(bus.mfc), 0);
    op("lw20", 1'b1, 2'd2, 1'b0, 9'h020, 0, 0);
    chk("lw20_val", bus.data_out, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++)
      op("rnd", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 9'($urandom), $urandom, 0);

    n = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
